// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM-stage load/store unit and the memory system.
// The LSU is the master: it raises mem_req with address/enables/data and holds
// them until the memory answers with a single-cycle mem_ack (and mem_rdata).
interface mem_stage_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit for the RV32 pipeline. Takes one load or store
// from EX/MEM, checks funct3/alignment, issues a held req/ack memory access,
// stalls the front of the pipe while busy, and returns extended load data to
// write-back. Bad accesses and bus timeouts are reported as one-cycle pulses.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic               op_load,
  input  logic               op_store,
  input  logic [2:0]         op_funct3,
  input  logic [31:0]        op_addr,
  input  logic [31:0]        op_wdata,
  input  logic [4:0]         op_rd,
  mem_stage_lsu_if.master    mem,
  output logic               stall,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               misalign_err,
  output logic               bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nx;
  logic               accept, legal, acc_ok, acc_bad;
  logic               ack_hit, tmo_hit;
  logic               ld_p1;
  logic [2:0]         f3_p1;
  logic [4:0]         rd_p1;
  logic [1:0]         off_p1;
  logic [CNT_W-1:0]   cnt_p1;

  // funct3 legality combined with natural alignment for the access size
  function automatic logic is_legal(input logic ld, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ld;
      3'b101:  ok = ld & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << a;
      3'b001:  be = 4'b0011 << a;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store byte/half across all lanes; byte enables pick the lane
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rw);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rw[7:0];
      2'd1:    b = rw[15:8];
      2'd2:    b = rw[23:16];
      default: b = rw[31:24];
    endcase
    h = a[1] ? rw[31:16] : rw[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = rw;
    endcase
    return r;
  endfunction

  assign accept  = (state == IDLE) & op_valid & (op_load | op_store);
  assign legal   = is_legal(op_load, op_funct3, op_addr[1:0]);
  assign acc_ok  = accept & legal;
  assign acc_bad = accept & ~legal;
  assign ack_hit = (state == BUSY) & mem.mem_ack;
  // Ack in the last allowed cycle takes priority over the timeout
  assign tmo_hit = (state == BUSY) & ~mem.mem_ack &
                   (cnt_p1 == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state: IDLE -> BUSY on a legal accept, back on ack or timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (acc_ok) state_nx = BUSY;
      BUSY:    if (ack_hit | tmo_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stall is combinational so upstream freezes in the accept cycle itself
  always_comb begin
    stall = rst & ((state == BUSY) | acc_ok);
  end

  // Stage 0 -> 1: latch the accepted operation and run the timeout counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_p1  <= 1'b0;
      f3_p1  <= 3'd0;
      rd_p1  <= 5'd0;
      off_p1 <= 2'd0;
      cnt_p1 <= '0;
    end else if (acc_ok) begin
      ld_p1  <= op_load;
      f3_p1  <= op_funct3;
      rd_p1  <= op_rd;
      off_p1 <= op_addr[1:0];
      cnt_p1 <= '0;
    end else if ((state == BUSY) & ~ack_hit & ~tmo_hit) begin
      cnt_p1 <= cnt_p1 + CNT_W'(1);
    end else begin
      cnt_p1 <= '0;
    end
  end

  // Memory port registers: loaded on accept, held stable until the access ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= 32'd0;
      mem.mem_be    <= 4'd0;
      mem.mem_wdata <= 32'd0;
    end else begin
      mem.mem_req <= (state_nx == BUSY);
      if (acc_ok) begin
        mem.mem_we    <= op_store;
        mem.mem_addr  <= {op_addr[31:2], 2'b00};
        mem.mem_be    <= op_store ? store_be(op_funct3, op_addr[1:0]) : 4'b1111;
        mem.mem_wdata <= store_data(op_funct3, op_wdata);
      end
    end
  end

  // Stage 1 -> 2: write-back of completed loads and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= acc_bad;
      bus_err      <= tmo_hit;
      if (ack_hit & ld_p1 & (rd_p1 != 5'd0)) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_p1;
        wb_data  <= load_extend(f3_p1, off_p1, mem.mem_rdata);
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a table of single-access vectors with
// hand-computed bus/write-back results, plus sequences for reset, timeout,
// ack-at-deadline and reset during an outstanding access.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0, op_load = 1'b0, op_store = 1'b0;
  logic [2:0]  op_funct3 = 3'd0;
  logic [31:0] op_addr = 32'd0, op_wdata = 32'd0;
  logic [4:0]  op_rd = 5'd0;
  logic        stall, wb_valid, misalign_err, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;

  mem_stage_lsu_if mem_bus ();

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_load(op_load), .op_store(op_store),
    .op_funct3(op_funct3), .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
    .mem(mem_bus.master),
    .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        bad;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        wbv;
    logic [31:0] wbd;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata,
                              input logic bad, input logic [3:0] be,
                              input logic [31:0] mwdata, input logic wbv,
                              input logic [31:0] wbd);
    vec_t v;
    v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.bad = bad; v.be = be; v.mwdata = mwdata; v.wbv = wbv; v.wbd = wbd;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd);
    op_valid = 1'b1; op_load = ld; op_store = st; op_funct3 = f3;
    op_addr = addr; op_wdata = wdata; op_rd = rd;
  endtask

  task automatic clear_op();
    op_valid = 1'b0; op_load = 1'b0; op_store = 1'b0;
  endtask

  // One access with ack in the first BUSY cycle
  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive_op(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    #1;
    chk1($sformatf("v%0d stall_accept", idx), stall, !v.bad);
    @(posedge clk); #1;
    clear_op();
    if (v.bad) begin
      chk1($sformatf("v%0d misalign", idx), misalign_err, 1'b1);
      chk1($sformatf("v%0d req_bad", idx), mem_bus.mem_req, 1'b0);
      chk1($sformatf("v%0d stall_bad", idx), stall, 1'b0);
    end else begin
      chk1($sformatf("v%0d req", idx), mem_bus.mem_req, 1'b1);
      chk1($sformatf("v%0d stall_busy", idx), stall, 1'b1);
      chk1($sformatf("v%0d we", idx), mem_bus.mem_we, v.st);
      chk32($sformatf("v%0d addr", idx), mem_bus.mem_addr, {v.addr[31:2], 2'b00});
      chk32($sformatf("v%0d be", idx), 32'(mem_bus.mem_be), 32'(v.be));
      if (v.st) chk32($sformatf("v%0d wdata", idx), mem_bus.mem_wdata, v.mwdata);
      chk1($sformatf("v%0d misalign_ok", idx), misalign_err, 1'b0);
      mem_bus.mem_ack = 1'b1;
      mem_bus.mem_rdata = v.rdata;
    end
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk1($sformatf("v%0d req_done", idx), mem_bus.mem_req, 1'b0);
    chk1($sformatf("v%0d stall_done", idx), stall, 1'b0);
    chk1($sformatf("v%0d misalign_done", idx), misalign_err, 1'b0);
    chk1($sformatf("v%0d bus_err", idx), bus_err, 1'b0);
    chk1($sformatf("v%0d wb_valid", idx), wb_valid, v.wbv);
    if (v.wbv) begin
      chk32($sformatf("v%0d wb_data", idx), wb_data, v.wbd);
      chk32($sformatf("v%0d wb_rd", idx), 32'(wb_rd), 32'(v.rd));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] reqs, errs, wbvs, stls;

    //                ld  st  f3      addr          wdata         rd     rdata         bad be       mwdata        wbv wbd
    vecs[0]  = mk(1'b0,1'b1,3'b010,32'h0000_0100,32'h0000_0008,5'd1, 32'h0,        1'b0,4'b1111,32'h0000_0008,1'b0,32'h0);
    vecs[1]  = mk(1'b1,1'b0,3'b010,32'h0000_0100,32'h0,        5'd3, 32'h0000_0008,1'b0,4'b1111,32'h0,        1'b1,32'h0000_0008);
    vecs[2]  = mk(1'b1,1'b0,3'b000,32'h0000_0201,32'h0,        5'd5, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'h0000_007F);
    vecs[3]  = mk(1'b1,1'b0,3'b000,32'h0000_0203,32'h0,        5'd6, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'hFFFF_FF80);
    vecs[4]  = mk(1'b1,1'b0,3'b101,32'h0000_0202,32'h0,        5'd7, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'h0000_80FF);
    vecs[5]  = mk(1'b1,1'b0,3'b001,32'h0000_0202,32'h0,        5'd8, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'hFFFF_80FF);
    vecs[6]  = mk(1'b0,1'b1,3'b000,32'h0000_0305,32'h1234_56AB,5'd0, 32'h0,        1'b0,4'b0010,32'hABAB_ABAB,1'b0,32'h0);
    vecs[7]  = mk(1'b0,1'b1,3'b001,32'h0000_0306,32'hDEAD_1234,5'd0, 32'h0,        1'b0,4'b1100,32'h1234_1234,1'b0,32'h0);
    vecs[8]  = mk(1'b1,1'b0,3'b010,32'h0000_0402,32'h0,        5'd4, 32'h0,        1'b1,4'b0000,32'h0,        1'b0,32'h0);
    vecs[9]  = mk(1'b1,1'b0,3'b011,32'h0000_0400,32'h0,        5'd4, 32'h0,        1'b1,4'b0000,32'h0,        1'b0,32'h0);
    vecs[10] = mk(1'b0,1'b1,3'b001,32'h0000_0301,32'h0,        5'd0, 32'h0,        1'b1,4'b0000,32'h0,        1'b0,32'h0);
    vecs[11] = mk(1'b0,1'b1,3'b100,32'h0000_0300,32'h0,        5'd0, 32'h0,        1'b1,4'b0000,32'h0,        1'b0,32'h0);
    vecs[12] = mk(1'b1,1'b0,3'b100,32'h0000_0203,32'h0,        5'd9, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'h0000_0080);
    vecs[13] = mk(1'b1,1'b0,3'b001,32'h0000_0200,32'h0,        5'd10,32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b1,32'h0000_7F01);
    vecs[14] = mk(1'b1,1'b0,3'b100,32'h0000_0200,32'h0,        5'd0, 32'h80FF_7F01,1'b0,4'b1111,32'h0,        1'b0,32'h0);

    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 32'd0;

    // Reset held with a legal load presented: nothing may move
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
    repeat (2) @(posedge clk);
    #1;
    chk1("rst stall", stall, 1'b0);
    chk1("rst req", mem_bus.mem_req, 1'b0);
    chk1("rst we", mem_bus.mem_we, 1'b0);
    chk32("rst addr", mem_bus.mem_addr, 32'h0);
    chk32("rst be", 32'(mem_bus.mem_be), 32'h0);
    chk32("rst wdata", mem_bus.mem_wdata, 32'h0);
    chk1("rst wb_valid", wb_valid, 1'b0);
    chk32("rst wb_rd", 32'(wb_rd), 32'h0);
    chk32("rst wb_data", wb_data, 32'h0);
    chk1("rst misalign", misalign_err, 1'b0);
    chk1("rst bus_err", bus_err, 1'b0);
    clear_op();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // rd=0 load suppressed write-back; previous result must be held
    chk32("hold wb_rd", 32'(wb_rd), 32'd10);
    chk32("hold wb_data", wb_data, 32'h0000_7F01);

    // Timeout: ack never comes
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 5'd11);
    @(posedge clk); #1;
    clear_op();
    for (int c = 0; c < 6; c++) begin
      reqs[c] = mem_bus.mem_req;
      errs[c] = bus_err;
      wbvs[c] = wb_valid;
      stls[c] = stall;
      @(posedge clk); #1;
    end
    chk32("tmo req_cycles", 32'(reqs), 32'b001111);
    chk32("tmo bus_err", 32'(errs), 32'b010000);
    chk32("tmo wb_valid", 32'(wbvs), 32'b000000);
    chk32("tmo stall", 32'(stls), 32'b001111);

    // Ack in the 4th BUSY cycle beats the timeout
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0504, 32'h0, 5'd12);
    @(posedge clk); #1;
    clear_op();
    for (int c = 0; c < 3; c++) begin
      reqs[c] = mem_bus.mem_req;
      @(posedge clk); #1;
    end
    chk32("late req_cycles", 32'(reqs[2:0]), 32'b111);
    chk1("late req4", mem_bus.mem_req, 1'b1);
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk1("late req_drop", mem_bus.mem_req, 1'b0);
    chk1("late bus_err", bus_err, 1'b0);
    chk1("late wb_valid", wb_valid, 1'b1);
    chk32("late wb_data", wb_data, 32'hCAFE_F00D);
    chk32("late wb_rd", 32'(wb_rd), 32'd12);
    @(posedge clk); #1;
    chk1("late bus_err_after", bus_err, 1'b0);
    chk1("late wb_pulse", wb_valid, 1'b0);

    // Reset during BUSY aborts at once; a stray ack afterwards is ignored
    @(negedge clk);
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd13);
    @(posedge clk); #1;
    clear_op();
    chk1("abort req_before", mem_bus.mem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk1("abort req", mem_bus.mem_req, 1'b0);
    chk1("abort stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    mem_bus.mem_ack = 1'b0;
    chk1("stray wb_valid", wb_valid, 1'b0);
    chk1("stray req", mem_bus.mem_req, 1'b0);
    chk1("stray stall", stall, 1'b0);
    run_vec(mk(1'b1,1'b0,3'b010,32'h0000_0700,32'h0,5'd14,32'h7654_3210,1'b0,4'b1111,32'h0,1'b1,32'h7654_3210), 15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage of the pipelined RV32 core, downstream of EX and upstream of the register-file write-back path.
- Accepts one load or store per transaction from EX/MEM and drives a req/ack data-memory port.
- Aligns store bytes and sign/zero-extends load data.
- Holds the pipeline stall until the access completes.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16, number of BUSY cycles without mem_ack before bus_err is raised; the minimum legal value is 1.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX/MEM holds a valid memory operation this cycle.
- op_load  in  1  the operation is a load.
- op_store  in  1  the operation is a store. op_load and op_store are never both 1.
- op_funct3  in  3  RV32 funct3 of the load/store.
- op_addr  in  32  effective byte address.
- op_wdata  in  32  store data (rs2).
- op_rd  in  5  load destination register.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: {op_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned store data.
- mem_rdata  in  32  read word; valid with mem_ack.
- mem_ack  in  1  single-cycle completion strobe.
- stall  out  1  freeze IF/ID/EX and hold EX/MEM.
- wb_valid  out  1  load result valid (one-cycle pulse).
- wb_rd  out  5  destination register for wb_data.
- wb_data  out  32  extended load data.
- misalign_err  out  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_err  out  1  one-cycle pulse: access timed out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE and the timeout counter clears.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, wb_valid, wb_rd, wb_data, misalign_err and bus_err are all 0.
  - stall is 0 while reset is asserted.
- States are IDLE and BUSY.
- Accept: in IDLE, an operation is accepted when op_valid=1 and (op_load or op_store).
- Legality check at accept:
  - Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
  - Alignment: a halfword needs addr[0]=0; a word needs addr[1:0]=00.
  - Illegal or misaligned: misalign_err pulses the next cycle, no memory access is made, the state stays IDLE, and stall stays 0.
- Legal accept:
  - stall=1 combinationally in the accept cycle.
  - Next cycle: state=BUSY and mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata registered from the latched operation.
  - These outputs stay stable until mem_ack.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{byte}}.
  - SH: be=0011<<addr[1:0], wdata={2{half}}.
  - SW: be=1111, wdata=op_wdata.
- Loads drive mem_we=0 and mem_be=1111.
- stall = (state==BUSY) | (IDLE & legal accept).
- mem_ack in BUSY:
  - mem_req drops the next cycle and state goes to IDLE.
  - stall deasserts combinationally in that next cycle.
  - For a load, in that next cycle wb_valid=1, wb_rd=latched rd, and wb_data = the lane selected by addr[1:0]:
    - LB/LH sign-extend.
    - LBU/LHU zero-extend.
    - LW passes the word through.
  - wb_valid is suppressed when rd=0.
  - Stores never assert wb_valid.
- Latency: with mem_ack in the first BUSY cycle, accept at cycle N gives mem_req at N+1 and wb_valid at N+2.
- Timeout:
  - The counter increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES: bus_err pulses, mem_req drops, state goes to IDLE, and there is no write-back.
  - mem_ack arriving in the same cycle as the timeout wins: normal completion, no bus_err.
- Ignored events:
  - mem_ack while IDLE.
  - op_valid while BUSY (upstream is held by stall).
- Reset mid-transaction aborts immediately and no write-back occurs.
- wb_data and wb_rd hold their last values when wb_valid=0.

Test Plan:
- SW x1=8 to 0x100, then LW x3 from 0x100 with ack 1 cycle after req -> mem_be=1111 and mem_we=1 for the store; load gives wb_valid at accept+2, wb_rd=3, wb_data=0x00000008; stall high exactly 2 cycles per op.
- Memory word 0x80FF7F01 at 0x200: LB 0x201 -> 0x0000007F; LB 0x203 -> 0xFFFFFF80; LHU 0x202 -> 0x000080FF; LH 0x202 -> 0xFFFF80FF.
- SB 0xAB to 0x305 -> mem_addr=0x304, mem_be=0010, mem_wdata=0xABABABAB; SH 0x1234 to 0x306 -> mem_be=1100, mem_wdata=0x12341234.
- LW at 0x402, and load with funct3=011 -> misalign_err pulse, mem_req never asserted, stall stays 0.
- TIMEOUT_CYCLES=4, ack withheld -> mem_req high 4 cycles, bus_err pulse, state IDLE, no wb_valid; repeat with ack in the 4th BUSY cycle -> normal completion, no bus_err.
- Load accepted, rst=0 during BUSY -> mem_req and stall drop immediately; after release, a late ack is ignored and the next LW completes normally.
